// File: rtl/uiip_tx_sched.sv
// ---------------------------------------------------------------------------
// uiip_tx_sched
//   Shares the IP transmit path between ICMP echo replies and UDP frames.
//   ICMP reply descriptors are buffered in a small FIFO.  When both sources
//   are pending they are served round-robin.  A single req/ack/done session
//   is driven toward the IP transmit module, followed by an inter-frame gap.
//   A watchdog ends a session whose done never arrives.
//
// Ports
//   I_clk, I_reset_n            clock, asynchronous active-low reset
//   I_icmp_req_*/I_icmp_echo_len ICMP descriptor push (pulse + fields)
//   I_udp_req, I_udp_len        UDP level request and payload length
//   O_udp_grant                 one-cycle pulse when the UDP session is acked
//   O_ip_tx_req/type/len        session request toward IP TX
//   O_icmp_id/sq_num/checksum   ICMP fields of the current session
//   I_ip_tx_ack, I_ip_tx_done   IP TX handshake
//   O_icmp_pending              queued ICMP descriptors
//   O_icmp_drop_cnt             dropped ICMP requests (saturating)
//   O_tx_timeout                one-cycle pulse when the watchdog expires
// ---------------------------------------------------------------------------
module uiip_tx_sched #(
    parameter int QDEPTH         = 4,
    parameter int IFG_CYCLES     = 12,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        I_clk,
    input  logic        I_reset_n,
    input  logic        I_icmp_req_en,
    input  logic [15:0] I_icmp_req_id,
    input  logic [15:0] I_icmp_req_sq_num,
    input  logic [15:0] I_icmp_req_checksum,
    input  logic [9:0]  I_icmp_echo_len,
    input  logic        I_udp_req,
    input  logic [15:0] I_udp_len,
    output logic        O_udp_grant,
    output logic        O_ip_tx_req,
    output logic [7:0]  O_ip_tx_type,
    output logic [15:0] O_ip_tx_len,
    output logic [15:0] O_icmp_id,
    output logic [15:0] O_icmp_sq_num,
    output logic [15:0] O_icmp_checksum,
    input  logic        I_ip_tx_ack,
    input  logic        I_ip_tx_done,
    output logic [4:0]  O_icmp_pending,
    output logic [7:0]  O_icmp_drop_cnt,
    output logic        O_tx_timeout
);

    localparam int              AW       = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
    localparam logic [4:0]      Q_FULL   = 5'(QDEPTH);
    localparam logic [15:0]     TO_M1    = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]      IFG_M1   = 8'((IFG_CYCLES > 0) ? (IFG_CYCLES - 1) : 0);
    localparam logic            IFG_ZERO = (IFG_CYCLES == 0);

    localparam logic [7:0]      TYPE_ICMP = 8'h01;
    localparam logic [7:0]      TYPE_UDP  = 8'h11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_BUSY = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

    // Descriptor storage
    logic [15:0] id_mem_r  [QDEPTH];
    logic [15:0] sq_mem_r  [QDEPTH];
    logic [15:0] cks_mem_r [QDEPTH];
    logic [9:0]  len_mem_r [QDEPTH];

    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [4:0]    count_r;
    logic [7:0]    drop_cnt_r;

    logic [1:0]    state_r;
    logic          sess_icmp_r;
    logic          last_icmp_r;     // 0 = UDP served last, so ICMP wins the first tie
    logic [15:0]   wd_r;
    logic [7:0]    gap_r;

    logic          req_r;
    logic [7:0]    type_r;
    logic [15:0]   len_r;
    logic [15:0]   icmp_id_r;
    logic [15:0]   icmp_sq_r;
    logic [15:0]   icmp_cks_r;
    logic          udp_grant_r;
    logic          timeout_r;

    logic          pop_s;
    logic          full_s;
    logic          push_s;
    logic          drop_s;
    logic          icmp_pend_s;
    logic          start_s;
    logic          pick_icmp_s;

    // Queue handshake decode; a pop frees a slot for a same-cycle push
    assign pop_s       = (state_r == ST_REQ) && I_ip_tx_ack && sess_icmp_r;
    assign full_s      = (count_r == Q_FULL);
    assign push_s      = I_icmp_req_en && (!full_s || pop_s);
    assign drop_s      = I_icmp_req_en && !push_s;
    assign icmp_pend_s = (count_r != 5'd0);
    assign start_s     = (state_r == ST_IDLE) && (icmp_pend_s || I_udp_req);

    // Round-robin selection between ICMP and UDP
    always_comb begin
        pick_icmp_s = 1'b0;
        if (icmp_pend_s && I_udp_req) begin
            pick_icmp_s = !last_icmp_r;
        end else if (icmp_pend_s) begin
            pick_icmp_s = 1'b1;
        end else begin
            pick_icmp_s = 1'b0;
        end
    end

    // Descriptor write port
    always_ff @(posedge I_clk) begin
        if (push_s) begin
            id_mem_r[wr_ptr_r]  <= I_icmp_req_id;
            sq_mem_r[wr_ptr_r]  <= I_icmp_req_sq_num;
            cks_mem_r[wr_ptr_r] <= I_icmp_req_checksum;
            len_mem_r[wr_ptr_r] <= I_icmp_echo_len;
        end
    end

    // Queue pointers, occupancy and saturating drop counter
    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= 5'd0;
            drop_cnt_r <= 8'd0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_r + {4'd0, push_s} - {4'd0, pop_s};
            if (drop_s && (drop_cnt_r != 8'hFF)) begin
                drop_cnt_r <= drop_cnt_r + 8'd1;
            end
        end
    end

    // Session FSM with registered request fields, watchdog and gap counter
    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            state_r     <= ST_IDLE;
            sess_icmp_r <= 1'b0;
            last_icmp_r <= 1'b0;
            wd_r        <= 16'd0;
            gap_r       <= 8'd0;
            req_r       <= 1'b0;
            type_r      <= 8'd0;
            len_r       <= 16'd0;
            icmp_id_r   <= 16'd0;
            icmp_sq_r   <= 16'd0;
            icmp_cks_r  <= 16'd0;
            udp_grant_r <= 1'b0;
            timeout_r   <= 1'b0;
        end else begin
            udp_grant_r <= 1'b0;
            timeout_r   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        state_r     <= ST_REQ;
                        req_r       <= 1'b1;
                        sess_icmp_r <= pick_icmp_s;
                        if (pick_icmp_s) begin
                            type_r     <= TYPE_ICMP;
                            len_r      <= 16'd8 + {6'd0, len_mem_r[rd_ptr_r]};
                            icmp_id_r  <= id_mem_r[rd_ptr_r];
                            icmp_sq_r  <= sq_mem_r[rd_ptr_r];
                            icmp_cks_r <= cks_mem_r[rd_ptr_r];
                        end else begin
                            type_r     <= TYPE_UDP;
                            len_r      <= I_udp_len + 16'd8;
                            icmp_id_r  <= 16'd0;
                            icmp_sq_r  <= 16'd0;
                            icmp_cks_r <= 16'd0;
                        end
                    end
                end
                ST_REQ: begin
                    if (I_ip_tx_ack) begin
                        state_r     <= ST_BUSY;
                        req_r       <= 1'b0;
                        wd_r        <= 16'd0;
                        last_icmp_r <= sess_icmp_r;
                        udp_grant_r <= !sess_icmp_r;
                    end
                end
                ST_BUSY: begin
                    // done wins over a watchdog expiry in the same cycle
                    if (I_ip_tx_done || (wd_r == TO_M1)) begin
                        state_r   <= IFG_ZERO ? ST_IDLE : ST_GAP;
                        gap_r     <= 8'd0;
                        timeout_r <= !I_ip_tx_done;
                    end else begin
                        wd_r <= wd_r + 16'd1;
                    end
                end
                ST_GAP: begin
                    if (gap_r == IFG_M1) begin
                        state_r <= ST_IDLE;
                    end else begin
                        gap_r <= gap_r + 8'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign O_udp_grant     = udp_grant_r;
    assign O_ip_tx_req     = req_r;
    assign O_ip_tx_type    = type_r;
    assign O_ip_tx_len     = len_r;
    assign O_icmp_id       = icmp_id_r;
    assign O_icmp_sq_num   = icmp_sq_r;
    assign O_icmp_checksum = icmp_cks_r;
    assign O_icmp_pending  = count_r;
    assign O_icmp_drop_cnt = drop_cnt_r;
    assign O_tx_timeout    = timeout_r;

endmodule

// File: tb/tb_uiip_tx_sched.sv
// ---------------------------------------------------------------------------
// tb_uiip_tx_sched
//   Directed bench for uiip_tx_sched.  Expected sessions are queued when the
//   stimulus is issued; a monitor pops and compares them on every rising
//   O_ip_tx_req.  Timing, occupancy and counter checks are made inline.
// ---------------------------------------------------------------------------
module tb_uiip_tx_sched;

    localparam int TO_CYC  = 40;
    localparam int IFG_CYC = 12;

    logic        clk;
    logic        rst_n;
    logic        icmp_en;
    logic [15:0] icmp_id;
    logic [15:0] icmp_sq;
    logic [15:0] icmp_cks;
    logic [9:0]  icmp_len;
    logic        udp_req;
    logic [15:0] udp_len;
    logic        udp_grant;
    logic        tx_req;
    logic [7:0]  tx_type;
    logic [15:0] tx_len;
    logic [15:0] o_id;
    logic [15:0] o_sq;
    logic [15:0] o_cks;
    logic        tx_ack;
    logic        tx_done;
    logic [4:0]  pending;
    logic [7:0]  drop_cnt;
    logic        tx_timeout;

    typedef struct {
        logic [7:0]  typ;
        logic [15:0] len;
        logic [15:0] id;
        logic [15:0] sq;
        logic [15:0] cks;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   errors;
    int   cyc;
    int   grant_cnt;
    int   to_cnt;

    uiip_tx_sched #(
        .QDEPTH(4),
        .IFG_CYCLES(IFG_CYC),
        .TIMEOUT_CYCLES(TO_CYC)
    ) dut (
        .I_clk(clk),
        .I_reset_n(rst_n),
        .I_icmp_req_en(icmp_en),
        .I_icmp_req_id(icmp_id),
        .I_icmp_req_sq_num(icmp_sq),
        .I_icmp_req_checksum(icmp_cks),
        .I_icmp_echo_len(icmp_len),
        .I_udp_req(udp_req),
        .I_udp_len(udp_len),
        .O_udp_grant(udp_grant),
        .O_ip_tx_req(tx_req),
        .O_ip_tx_type(tx_type),
        .O_ip_tx_len(tx_len),
        .O_icmp_id(o_id),
        .O_icmp_sq_num(o_sq),
        .O_icmp_checksum(o_cks),
        .I_ip_tx_ack(tx_ack),
        .I_ip_tx_done(tx_done),
        .O_icmp_pending(pending),
        .O_icmp_drop_cnt(drop_cnt),
        .O_tx_timeout(tx_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge counter: at the negedge after edge k, cyc == k
    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_req"},     32'(tx_req),     32'd0);
        check({tag, "_type"},    32'(tx_type),    32'd0);
        check({tag, "_len"},     32'(tx_len),     32'd0);
        check({tag, "_id"},      32'(o_id),       32'd0);
        check({tag, "_sq"},      32'(o_sq),       32'd0);
        check({tag, "_cks"},     32'(o_cks),      32'd0);
        check({tag, "_pending"}, 32'(pending),    32'd0);
        check({tag, "_drop"},    32'(drop_cnt),   32'd0);
        check({tag, "_grant"},   32'(udp_grant),  32'd0);
        check({tag, "_timeout"}, 32'(tx_timeout), 32'd0);
    endtask

    task automatic exp_icmp(input logic [15:0] id, input logic [15:0] sq,
                            input logic [15:0] cks, input logic [9:0] len);
        exp_t e;
        e.typ = 8'h01;
        e.len = 16'd8 + {6'd0, len};
        e.id  = id;
        e.sq  = sq;
        e.cks = cks;
        exp_q.push_back(e);
    endtask

    // One-cycle push; called and returns on a negedge
    task automatic push(input logic [15:0] id, input logic [15:0] sq,
                        input logic [15:0] cks, input logic [9:0] len, input bit expect_sess);
        icmp_en  = 1'b1;
        icmp_id  = id;
        icmp_sq  = sq;
        icmp_cks = cks;
        icmp_len = len;
        if (expect_sess) exp_icmp(id, sq, cks, len);
        @(negedge clk);
        icmp_en = 1'b0;
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        while (!tx_req && n < 300) begin
            @(negedge clk);
            n = n + 1;
        end
        check("req_wait_bound", 32'(tx_req), 32'd1);
    endtask

    task automatic finish_session(input int busy);
        tx_ack = 1'b1;
        @(negedge clk);
        tx_ack = 1'b0;
        repeat (busy) @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    // Monitor: compare every new session against the scoreboard
    initial begin
        logic prev_req;
        exp_t e;
        prev_req  = 1'b0;
        grant_cnt = 0;
        to_cnt    = 0;
        forever begin
            @(negedge clk);
            if (tx_req && !prev_req) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_req", 32'(tx_req), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sess_type", 32'(tx_type), 32'(e.typ));
                    check("sess_len",  32'(tx_len),  32'(e.len));
                    check("sess_id",   32'(o_id),    32'(e.id));
                    check("sess_sq",   32'(o_sq),    32'(e.sq));
                    check("sess_cks",  32'(o_cks),   32'(e.cks));
                end
            end
            prev_req = tx_req;
            if (udp_grant)  grant_cnt = grant_cnt + 1;
            if (tx_timeout) to_cnt = to_cnt + 1;
        end
    end

    initial begin
        int d;
        int a;
        int t;
        int n;
        int seen;
        exp_t u;
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        icmp_en  = 1'b0;
        icmp_id  = 16'd0;
        icmp_sq  = 16'd0;
        icmp_cks = 16'd0;
        icmp_len = 10'd0;
        udp_req  = 1'b0;
        udp_len  = 16'd0;
        tx_ack   = 1'b0;
        tx_done  = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Single ICMP session: request two edges after the push
        icmp_en  = 1'b1;
        icmp_id  = 16'h1234;
        icmp_sq  = 16'h0001;
        icmp_cks = 16'hABCD;
        icmp_len = 10'd32;
        exp_icmp(16'h1234, 16'h0001, 16'hABCD, 10'd32);
        @(negedge clk);
        icmp_en = 1'b0;
        check("t1_pending_after_push", 32'(pending), 32'd1);
        check("t1_req_not_yet", 32'(tx_req), 32'd0);
        @(negedge clk);
        check("t1_req_latency", 32'(tx_req), 32'd1);
        tx_ack = 1'b1;
        @(negedge clk);
        tx_ack = 1'b0;
        check("t1_pending_after_ack", 32'(pending), 32'd0);
        check("t1_req_dropped", 32'(tx_req), 32'd0);
        repeat (3) @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        d = cyc;
        // A push during the gap must wait for IDLE: 12 gap cycles + 1 idle
        push(16'h2222, 16'h0002, 16'h5555, 10'd4, 1'b1);
        wait_req();
        check("t1_ifg_length", 32'(cyc - d), 32'(IFG_CYC + 1));
        finish_session(2);
        repeat (20) @(negedge clk);

        // Round robin: ICMP C, then UDP, then ICMP D (last served was ICMP)
        push(16'h3333, 16'h0002, 16'h1111, 10'd0, 1'b1);
        push(16'h4444, 16'h0003, 16'h2222, 10'd1023, 1'b0);
        wait_req();
        udp_req = 1'b1;
        udp_len = 16'd100;
        u.typ = 8'h11;
        u.len = 16'd108;
        u.id  = 16'd0;
        u.sq  = 16'd0;
        u.cks = 16'd0;
        exp_q.push_back(u);
        exp_icmp(16'h4444, 16'h0003, 16'h2222, 10'd1023);
        finish_session(2);
        wait_req();
        check("t2_pending_during_udp", 32'(pending), 32'd1);
        tx_ack = 1'b1;
        @(negedge clk);
        tx_ack = 1'b0;
        check("t2_udp_grant_pulse", 32'(udp_grant), 32'd1);
        udp_req = 1'b0;
        @(negedge clk);
        check("t2_udp_grant_end", 32'(udp_grant), 32'd0);
        repeat (2) @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        wait_req();
        finish_session(1);
        repeat (20) @(negedge clk);

        // Overflow: 6 pushes into a depth-4 queue with no ack
        for (int i = 0; i < 6; i++) begin
            icmp_en  = 1'b1;
            icmp_id  = 16'h5000 + 16'(i);
            icmp_sq  = 16'h0010 + 16'(i);
            icmp_cks = 16'hC000 + 16'(i);
            icmp_len = 10'(8 * i);
            if (i < 4) exp_icmp(icmp_id, icmp_sq, icmp_cks, icmp_len);
            @(negedge clk);
        end
        icmp_en = 1'b0;
        check("t3_pending_full", 32'(pending), 32'd4);
        check("t3_drop_two", 32'(drop_cnt), 32'd2);
        // Push and ack together while full: accepted, nothing dropped
        icmp_en  = 1'b1;
        icmp_id  = 16'h5007;
        icmp_sq  = 16'h0017;
        icmp_cks = 16'hC007;
        icmp_len = 10'd56;
        tx_ack   = 1'b1;
        @(negedge clk);
        icmp_en = 1'b0;
        tx_ack  = 1'b0;
        check("t3_pending_push_pop", 32'(pending), 32'd4);
        check("t3_drop_unchanged", 32'(drop_cnt), 32'd2);
        repeat (2) @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;

        // Watchdog: ack, withhold done
        wait_req();
        tx_ack = 1'b1;
        @(negedge clk);
        tx_ack = 1'b0;
        a = cyc;
        n = 0;
        while (!tx_timeout && n < 200) begin
            @(negedge clk);
            n = n + 1;
        end
        t = cyc;
        check("t4_timeout_seen", 32'(tx_timeout), 32'd1);
        check("t4_timeout_delay", 32'(t - a), 32'(TO_CYC));
        @(negedge clk);
        check("t4_timeout_one_cycle", 32'(tx_timeout), 32'd0);
        tx_done = 1'b1;     // late done, must be ignored
        @(negedge clk);
        tx_done = 1'b0;
        wait_req();
        check("t4_ifg_after_timeout", 32'(cyc - t), 32'(IFG_CYC + 1));

        // Reset during BUSY with 3 queued descriptors
        tx_ack = 1'b1;
        @(negedge clk);
        tx_ack = 1'b0;
        push(16'h6666, 16'h0066, 16'h6666, 10'd6, 1'b0);
        check("t5_pending_before_reset", 32'(pending), 32'd3);
        rst_n = 1'b0;
        #1;
        check_zero("t5_async");
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (tx_req) seen = seen + 1;
        end
        check("t5_no_req_after_reset", 32'(seen), 32'd0);
        push(16'h7777, 16'h0077, 16'h7777, 10'd10, 1'b1);
        wait_req();
        finish_session(1);

        // Drop counter saturation: 4 accepted then 300 drops
        for (int i = 1; i <= 304; i++) begin
            icmp_en  = 1'b1;
            icmp_id  = 16'h8888;
            icmp_sq  = 16'(i);
            icmp_cks = 16'h8888;
            icmp_len = 10'd2;
            if (i == 1) exp_icmp(16'h8888, 16'd1, 16'h8888, 10'd2);
            @(negedge clk);
            if (i == 258) check("t6_drop_254", 32'(drop_cnt), 32'd254);
            if (i == 259) check("t6_drop_255", 32'(drop_cnt), 32'd255);
        end
        icmp_en = 1'b0;
        @(negedge clk);
        check("t6_drop_saturated", 32'(drop_cnt), 32'd255);
        check("t6_pending_full", 32'(pending), 32'd4);

        check("end_grant_count", 32'(grant_cnt), 32'd1);
        check("end_timeout_count", 32'(to_cnt), 32'd1);
        check("end_scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
